interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/pa_cpu_pkg.sv | 13 +
 rtl/irq_edge_detect.sv | 34 +++
 rtl/interrupt_controller.sv | 109 ++++++++++
 tb/tb_interrupt_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pa_cpu_pkg.sv
// Shared CPU-level constants and types for the interrupt controller.
package pa_cpu;

    localparam int unsigned NBR_IRQ          = 8;
    localparam int unsigned IRQ_IDX_W        = $clog2(NBR_IRQ);
    localparam int unsigned INT_VECTOR_SHIFT = 1;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        VECTORED = 1'b1
    } e_int_state;

endpackage

// File: rtl/irq_edge_detect.sv
// One interrupt line: 2-flop synchronizer plus rising-edge pulse.
module irq_edge_detect (
    input  logic clk,
    input  logic arst,
    input  logic irq,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;
    logic primed;
    logic armed;

    // A line already high when reset releases must first be seen low before an edge may count.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            primed <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync1  <= irq;
            sync2  <= sync1;
            prev   <= sync2;
            primed <= 1'b1;
            armed  <= armed | (primed & ~sync1);
        end
    end

    assign rise = sync2 & ~prev & armed;

endmodule

// File: rtl/interrupt_controller.sv
// Eight-line prioritised interrupt controller with mask register and vector latch.
module interrupt_controller
    import pa_cpu::*;
(
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] irq_in,
    input  logic [7:0] z_bus,
    input  logic       irq_en,
    input  logic       ctrl_irq_masks_wrt,
    input  logic       ctrl_int_vector_wrt,
    input  logic       ctrl_int_ack,
    input  logic       ctrl_clear_all_ints,
    output logic       int_pending,
    output logic [7:0] int_vector,
    output logic [7:0] irq_masks,
    output logic [7:0] irq_status,
    output logic       in_service
);

    logic [NBR_IRQ-1:0]   rise;
    logic [NBR_IRQ-1:0]   pending;
    logic [NBR_IRQ-1:0]   pending_next;
    logic [NBR_IRQ-1:0]   clr_mask;
    logic [NBR_IRQ-1:0]   serviceable;
    logic [NBR_IRQ-1:0]   masks;
    logic [IRQ_IDX_W-1:0] vec_idx;
    logic [IRQ_IDX_W-1:0] vec_idx_next;
    logic [IRQ_IDX_W-1:0] svc_idx;
    logic                 svc_any;
    e_int_state           state;
    e_int_state           state_next;

    for (genvar g = 0; g < NBR_IRQ; g++) begin : g_line
        irq_edge_detect u_edge (
            .clk  (clk),
            .arst (arst),
            .irq  (irq_in[g]),
            .rise (rise[g])
        );
    end

    assign serviceable = pending & masks;

    // Scan from the top down so the lowest serviceable index wins.
    always_comb begin
        svc_any = 1'b0;
        svc_idx = '0;
        for (int unsigned i = NBR_IRQ; i > 0; i--) begin
            if (serviceable[i-1]) begin
                svc_any = 1'b1;
                svc_idx = IRQ_IDX_W'(i - 1);
            end
        end
    end

    // clear_all outranks ack, and ack outranks a re-latch in the same cycle.
    always_comb begin
        state_next   = state;
        vec_idx_next = vec_idx;
        clr_mask     = '0;
        if (ctrl_clear_all_ints) begin
            state_next = IDLE;
            clr_mask   = '1;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_int_vector_wrt && svc_any) begin
                        state_next   = VECTORED;
                        vec_idx_next = svc_idx;
                    end
                end
                VECTORED: begin
                    if (ctrl_int_ack) begin
                        state_next = IDLE;
                        clr_mask   = {{(NBR_IRQ-1){1'b0}}, 1'b1} << vec_idx;
                    end else if (ctrl_int_vector_wrt && svc_any) begin
                        vec_idx_next = svc_idx;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        pending_next = (pending & ~clr_mask) | rise;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state   <= IDLE;
            vec_idx <= '0;
            pending <= '0;
            masks   <= '0;
        end else begin
            state   <= state_next;
            vec_idx <= vec_idx_next;
            pending <= pending_next;
            if (ctrl_irq_masks_wrt) begin
                masks <= z_bus;
            end
        end
    end

    assign int_pending = irq_en & (|serviceable);
    assign int_vector  = 8'(vec_idx) << INT_VECTOR_SHIFT;
    assign irq_masks   = masks;
    assign irq_status  = pending;
    assign in_service  = (state == VECTORED);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       arst;
    logic [7:0] irq_in;
    logic [7:0] z_bus;
    logic       irq_en;
    logic       ctrl_irq_masks_wrt;
    logic       ctrl_int_vector_wrt;
    logic       ctrl_int_ack;
    logic       ctrl_clear_all_ints;
    logic       int_pending;
    logic [7:0] int_vector;
    logic [7:0] irq_masks;
    logic [7:0] irq_status;
    logic       in_service;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .clk                 (clk),
        .arst                (arst),
        .irq_in              (irq_in),
        .z_bus               (z_bus),
        .irq_en              (irq_en),
        .ctrl_irq_masks_wrt  (ctrl_irq_masks_wrt),
        .ctrl_int_vector_wrt (ctrl_int_vector_wrt),
        .ctrl_int_ack        (ctrl_int_ack),
        .ctrl_clear_all_ints (ctrl_clear_all_ints),
        .int_pending         (int_pending),
        .int_vector          (int_vector),
        .irq_masks           (irq_masks),
        .irq_status          (irq_status),
        .in_service          (in_service)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic raise_lines(input logic [7:0] m);
        irq_in = irq_in | m;
        repeat (3) tick();
        irq_in = irq_in & ~m;
        repeat (3) tick();
    endtask

    task automatic write_masks(input logic [7:0] v);
        z_bus = v;
        ctrl_irq_masks_wrt = 1'b1;
        tick();
        ctrl_irq_masks_wrt = 1'b0;
    endtask

    task automatic strobe(input logic vec, input logic ack, input logic clr);
        ctrl_int_vector_wrt = vec;
        ctrl_int_ack        = ack;
        ctrl_clear_all_ints = clr;
        tick();
        ctrl_int_vector_wrt = 1'b0;
        ctrl_int_ack        = 1'b0;
        ctrl_clear_all_ints = 1'b0;
    endtask

    initial begin
        arst = 1'b0;
        irq_in = '0;
        z_bus = '0;
        irq_en = 1'b1;
        ctrl_irq_masks_wrt = 1'b0;
        ctrl_int_vector_wrt = 1'b0;
        ctrl_int_ack = 1'b0;
        ctrl_clear_all_ints = 1'b0;
        repeat (3) tick();
        check("rst_status", irq_status, 8'h00);
        check("rst_masks", irq_masks, 8'h00);
        check("rst_vector", int_vector, 8'h00);
        check("rst_pending", {7'b0, int_pending}, 8'h00);
        check("rst_service", {7'b0, in_service}, 8'h00);
        arst = 1'b1;
        repeat (3) tick();

        // single line 5, check exact set latency
        write_masks(8'hFF);
        check("masks_ff", irq_masks, 8'hFF);
        irq_in = 8'h20;
        tick();
        tick();
        check("l5_before_3rd", irq_status, 8'h00);
        tick();
        check("l5_status", irq_status, 8'h20);
        check("l5_intpend", {7'b0, int_pending}, 8'h01);
        repeat (3) tick();
        check("l5_level_no_reset", irq_status, 8'h20);
        irq_in = 8'h00;
        repeat (3) tick();
        strobe(1'b1, 1'b0, 1'b0);
        check("l5_vector", int_vector, 8'h0A);
        check("l5_service", {7'b0, in_service}, 8'h01);
        strobe(1'b0, 1'b1, 1'b0);
        check("l5_ack_status", irq_status, 8'h00);
        check("l5_ack_service", {7'b0, in_service}, 8'h00);
        check("l5_vector_hold", int_vector, 8'h0A);

        // lines 2 and 6: priority then ack then next
        raise_lines(8'h44);
        check("l26_status", irq_status, 8'h44);
        strobe(1'b1, 1'b0, 1'b0);
        check("l26_vec2", int_vector, 8'h04);
        strobe(1'b0, 1'b1, 1'b0);
        check("l26_ack", irq_status, 8'h40);
        strobe(1'b1, 1'b0, 1'b0);
        check("l26_vec6", int_vector, 8'h0C);
        // re-prioritise while vectored
        raise_lines(8'h02);
        strobe(1'b1, 1'b0, 1'b0);
        check("relatch_vec1", int_vector, 8'h02);
        check("relatch_service", {7'b0, in_service}, 8'h01);
        strobe(1'b0, 1'b1, 1'b0);
        check("relatch_ack", irq_status, 8'h40);

        // ack in IDLE ignored
        strobe(1'b0, 1'b1, 1'b0);
        check("idle_ack_ignored", irq_status, 8'h40);
        strobe(1'b0, 1'b0, 1'b1);
        check("clear_all", irq_status, 8'h00);

        // masked line 3, irq_en gating
        write_masks(8'h00);
        raise_lines(8'h08);
        check("l3_status", irq_status, 8'h08);
        check("l3_masked_intpend", {7'b0, int_pending}, 8'h00);
        strobe(1'b1, 1'b0, 1'b0);
        check("l3_novec_service", {7'b0, in_service}, 8'h00);
        check("l3_novec_vector", int_vector, 8'h02);
        write_masks(8'h08);
        check("l3_unmask_intpend", {7'b0, int_pending}, 8'h01);
        irq_en = 1'b0;
        #1;
        check("irq_en_gate", {7'b0, int_pending}, 8'h00);
        raise_lines(8'h10);
        check("irq_en_accum", irq_status, 8'h18);
        irq_en = 1'b1;
        strobe(1'b0, 1'b0, 1'b1);

        // new line-1 edge coincides with ack of line 1
        write_masks(8'hFF);
        raise_lines(8'h02);
        strobe(1'b1, 1'b0, 1'b0);
        check("l1_vector", int_vector, 8'h02);
        irq_in = 8'h02;
        tick();
        tick();
        strobe(1'b0, 1'b1, 1'b0);
        check("l1_edge_vs_ack", irq_status, 8'h02);
        check("l1_idle", {7'b0, in_service}, 8'h00);
        irq_in = 8'h00;
        repeat (3) tick();

        // all pending, clear_all beats vector_wrt
        raise_lines(8'hFF);
        check("all_status", irq_status, 8'hFF);
        strobe(1'b1, 1'b0, 1'b1);
        check("clr_vs_vec_status", irq_status, 8'h00);
        check("clr_vs_vec_service", {7'b0, in_service}, 8'h00);
        check("clr_vs_vec_intpend", {7'b0, int_pending}, 8'h00);

        // reset mid-VECTORED with line 0 held high across release
        raise_lines(8'h80);
        strobe(1'b1, 1'b0, 1'b0);
        check("l7_vector", int_vector, 8'h0E);
        irq_in = 8'h01;
        arst = 1'b0;
        #1;
        check("abort_service", {7'b0, in_service}, 8'h00);
        check("abort_vector", int_vector, 8'h00);
        check("abort_masks", irq_masks, 8'h00);
        repeat (2) tick();
        arst = 1'b1;
        write_masks(8'hFF);
        repeat (6) tick();
        check("held_no_edge", irq_status, 8'h00);
        irq_in = 8'h00;
        repeat (3) tick();
        raise_lines(8'h01);
        check("held_reraise", irq_status, 8'h01);
        check("held_reraise_intpend", {7'b0, int_pending}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
